// File: rtl/rv32i_types.sv
// Shared types for the rv32i front end: fetch FSM states and the instruction-queue entry.
package rv32i_types;

  localparam int IQ_XLEN = 32;
  localparam logic [3:0] IMEM_RMASK_WORD = 4'hF;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [IQ_XLEN-1:0] data;
    logic [IQ_XLEN-1:0] pc;
  } iq_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: keeps the fetch PC, issues single-outstanding imem reads, enqueues words into the IQ.
// Optional macro FETCH_PERF_EN adds saturating fetch/stall/discard counters as extra output ports.
//
// state   | meaning
// REQ     | issue a read at pc unless the queue is full or a flush arrives
// WAIT    | read outstanding at pc; enqueue or park the response
// HOLD    | response parked in the hold buffer, waiting for queue space
// DISCARD | stale read outstanding at stale_addr; its response is dropped
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic [3:0]      imem_rmask,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  input  logic            iq_full,
  output logic            iq_enq,
  output logic [XLEN-1:0] iq_wdata,
  output logic [XLEN-1:0] iq_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_discard_cnt
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] stale_addr;
  iq_t             hold_buf;
  logic            hold_ld;
  logic            stale_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      hold_buf   <= '0;
      stale_addr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (hold_ld) begin
        hold_buf.data <= imem_rdata;
        hold_buf.pc   <= pc;
      end
      if (stale_ld) stale_addr <= pc;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    imem_rmask = 4'h0;
    imem_addr  = pc;
    iq_enq     = 1'b0;
    iq_wdata   = '0;
    iq_pc      = '0;
    hold_ld    = 1'b0;
    stale_ld   = 1'b0;

    case (state)
      REQ: begin
        if (flush) begin
          pc_nxt = flush_pc;
        end else if (!iq_full) begin
          imem_rmask = IMEM_RMASK_WORD;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        imem_rmask = IMEM_RMASK_WORD;
        if (flush) begin
          pc_nxt = flush_pc;
          if (imem_resp) begin
            state_nxt = REQ;
          end else begin
            stale_ld  = 1'b1;
            state_nxt = DISCARD;
          end
        end else if (imem_resp) begin
          if (!iq_full) begin
            iq_enq    = 1'b1;
            iq_wdata  = imem_rdata;
            iq_pc     = pc;
            pc_nxt    = pc + XLEN'(4);
            state_nxt = REQ;
          end else begin
            hold_ld   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_nxt    = flush_pc;
          state_nxt = REQ;
        end else if (!iq_full) begin
          iq_enq    = 1'b1;
          iq_wdata  = hold_buf.data;
          iq_pc     = hold_buf.pc;
          pc_nxt    = pc + XLEN'(4);
          state_nxt = REQ;
        end
      end
      DISCARD: begin
        imem_rmask = IMEM_RMASK_WORD;
        imem_addr  = stale_addr;
        if (flush) pc_nxt = flush_pc;
        if (imem_resp) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    // Outputs are quiet for the whole reset cycle, whatever state we reset out of.
    if (rst) begin
      imem_rmask = 4'h0;
      iq_enq     = 1'b0;
      iq_wdata   = '0;
      iq_pc      = '0;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_evt;
  logic drop_evt;

  assign stall_evt = !rst && ((state == HOLD) || (state == REQ && iq_full));
  assign drop_evt  = !rst && imem_resp &&
                     ((state == WAIT && flush) || (state == DISCARD));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt   <= '0;
      perf_stall_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (iq_enq && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_evt && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (drop_evt && perf_discard_cnt != '1) perf_discard_cnt <= perf_discard_cnt + 16'd1;
    end
  end
`endif

endmodule
